// File: rtl/common_pkg.sv
`default_nettype none
// ============================================================================
// Module   : common (package)
// Purpose  : Shared integer-pipeline types for the register file slice.
// Revision : 1.0 - initial release
// ============================================================================
package common;

  localparam int c_xlen     = 32;
  localparam int c_areg_w   = 5;
  localparam int c_sb_cnt_w = 2;

  typedef logic [c_xlen-1:0]     word_t;
  typedef logic [c_areg_w-1:0]   creg_addr_t;
  typedef logic [c_sb_cnt_w-1:0] sb_cnt_t;

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : Per-register outstanding-write counters with busy lookups.
//            Optional macro REGFILE_BYPASS_EN treats a committing write as done.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
  import common::*;
#(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  creg_addr_t ra1,
  input  creg_addr_t ra2,
  output logic       busy1,
  output logic       busy2,
  input  logic       issue_valid,
  input  logic       issue_wen,
  input  creg_addr_t issue_dst,
  input  logic       wvalid,
  input  creg_addr_t wa,
  input  logic       flush,
  output logic       sb_overflow
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt     [NREG];
  logic [CNT_W-1:0] w_cnt_nxt [NREG];
  logic [NREG-1:0]  w_ovf;
  logic             r_ovf;
  logic             w_rsv_any;
  logic             w_rel_any;

  assign w_rsv_any = issue_valid && issue_wen && (issue_dst != '0);
  assign w_rel_any = wvalid && (wa != '0);

  for (genvar i = 0; i < NREG; i++) begin : g_cnt
    if (i == 0) begin : g_zero
      assign w_cnt_nxt[i] = '0;
      assign w_ovf[i]     = 1'b0;
    end else begin : g_reg
      logic w_rsv;
      logic w_rel;
      assign w_rsv = w_rsv_any && (issue_dst == creg_addr_t'(i));
      assign w_rel = w_rel_any && (wa == creg_addr_t'(i));
      // Flush wins over reserve; a simultaneous reserve+release cancels out.
      assign w_ovf[i] = !flush && w_rsv && !w_rel && (r_cnt[i] == c_cnt_max);
      assign w_cnt_nxt[i] =
          flush                                   ? '0 :
          (w_rsv && !w_rel && r_cnt[i] != c_cnt_max) ? r_cnt[i] + c_cnt_one :
          (w_rel && !w_rsv && r_cnt[i] != '0)        ? r_cnt[i] - c_cnt_one :
                                                       r_cnt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
      r_ovf <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) r_cnt[i] <= w_cnt_nxt[i];
      r_ovf <= r_ovf | (|w_ovf);
    end
  end

  assign sb_overflow = r_ovf;

  logic [CNT_W-1:0] w_cnt1;
  logic [CNT_W-1:0] w_cnt2;
  assign w_cnt1 = r_cnt[ra1];
  assign w_cnt2 = r_cnt[ra2];

`ifdef REGFILE_BYPASS_EN
  logic w_hit1, w_hit2, w_rsv1, w_rsv2;
  assign w_hit1 = w_rel_any && (wa == ra1);
  assign w_hit2 = w_rel_any && (wa == ra2);
  assign w_rsv1 = w_rsv_any && (issue_dst == ra1);
  assign w_rsv2 = w_rsv_any && (issue_dst == ra2);
  assign busy1 = (ra1 != '0) && (w_hit1 ? ((w_cnt1 > c_cnt_one) || (w_cnt1 == c_cnt_one && w_rsv1))
                                        : (w_cnt1 != '0));
  assign busy2 = (ra2 != '0) && (w_hit2 ? ((w_cnt2 > c_cnt_one) || (w_cnt2 == c_cnt_one && w_rsv2))
                                        : (w_cnt2 != '0));
`else
  assign busy1 = (ra1 != '0) && (w_cnt1 != '0);
  assign busy2 = (ra2 != '0) && (w_cnt2 != '0);
`endif

endmodule
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
// Module   : regfile
// Purpose  : 2R/1W integer register file with outstanding-write scoreboard.
//            Optional macro REGFILE_BYPASS_EN enables write-through forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module regfile
  import common::*;
#(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  creg_addr_t ra1,
  input  creg_addr_t ra2,
  output word_t      rd1,
  output word_t      rd2,
  output logic       busy1,
  output logic       busy2,
  input  logic       issue_valid,
  input  logic       issue_wen,
  input  creg_addr_t issue_dst,
  input  logic       wvalid,
  input  creg_addr_t wa,
  input  word_t      wd,
  input  logic       flush,
  output logic       sb_overflow
);

  word_t r_regs [NREG];
  word_t w_rd1_st;
  word_t w_rd2_st;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (wvalid && wa != '0) begin
      r_regs[wa] <= wd;
    end
  end

  assign w_rd1_st = (ra1 == '0) ? '0 : r_regs[ra1];
  assign w_rd2_st = (ra2 == '0) ? '0 : r_regs[ra2];

`ifdef REGFILE_BYPASS_EN
  assign rd1 = (wvalid && wa != '0 && wa == ra1) ? wd : w_rd1_st;
  assign rd2 = (wvalid && wa != '0 && wa == ra2) ? wd : w_rd2_st;
`else
  assign rd1 = w_rd1_st;
  assign rd2 = w_rd2_st;
`endif

  regfile_scoreboard #(
    .NREG  (NREG),
    .CNT_W (CNT_W)
  ) u_sb (
    .clk         (clk),
    .reset       (reset),
    .ra1         (ra1),
    .ra2         (ra2),
    .busy1       (busy1),
    .busy2       (busy2),
    .issue_valid (issue_valid),
    .issue_wen   (issue_wen),
    .issue_dst   (issue_dst),
    .wvalid      (wvalid),
    .wa          (wa),
    .flush       (flush),
    .sb_overflow (sb_overflow)
  );

endmodule
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile
// Purpose  : Directed self-checking bench for regfile.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile;
  import common::*;

  logic       clk = 1'b0;
  logic       reset;
  creg_addr_t ra1, ra2;
  word_t      rd1, rd2;
  logic       busy1, busy2;
  logic       issue_valid, issue_wen;
  creg_addr_t issue_dst;
  logic       wvalid;
  creg_addr_t wa;
  word_t      wd;
  logic       flush;
  logic       sb_overflow;

  int errors = 0;
  int checks = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit c_byp = 1'b1;
`else
  localparam bit c_byp = 1'b0;
`endif

  always #5 clk = ~clk;

  regfile dut (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2), .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_dst(issue_dst), .wvalid(wvalid), .wa(wa), .wd(wd), .flush(flush),
    .sb_overflow(sb_overflow)
  );

  // Advance past the next rising edge and drop all strobes.
  task automatic tick();
    @(posedge clk); #1;
    issue_valid = 0; issue_wen = 0; issue_dst = '0;
    wvalid = 0; wa = '0; wd = '0; flush = 0; reset = 0;
  endtask

  task automatic issue(input creg_addr_t d);
    issue_valid = 1; issue_wen = 1; issue_dst = d;
  endtask

  task automatic commit(input creg_addr_t a, input word_t d);
    wvalid = 1; wa = a; wd = d;
  endtask

  task automatic test_reset();
    reset = 1; ra1 = 5'd5; ra2 = '0;
    @(posedge clk); #1; @(posedge clk); #1;
    tick();
    #3;
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL reset_rd1 got=%h exp=0", rd1); end
    checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL reset_rd2 got=%h exp=0", rd2); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1 got=%b exp=0", busy1); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy2 got=%b exp=0", busy2); end
    checks++; if (sb_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", sb_overflow); end
  endtask

  task automatic test_write_read();
    ra1 = 5'd3;
    commit(5'd3, 32'hDEAD_BEEF);
    #3;
    checks++;
    if (rd1 !== (c_byp ? 32'hDEAD_BEEF : 32'h0)) begin
      errors++; $display("FAIL wr_same_cycle got=%h exp=%h", rd1, c_byp ? 32'hDEAD_BEEF : 32'h0);
    end
    tick(); #3;
    checks++; if (rd1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_next_cycle got=%h exp=deadbeef", rd1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL wr_busy got=%b exp=0", busy1); end
  endtask

  task automatic test_x0();
    commit('0, 32'h1);
    issue('0);
    ra1 = '0;
    tick(); #3;
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL x0_rd got=%h exp=0", rd1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL x0_busy got=%b exp=0", busy1); end
  endtask

  task automatic test_reserve_release();
    ra1 = 5'd7;
    issue(5'd7); tick();
    issue(5'd7); tick(); #3;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL rr_cnt2_busy got=%b exp=1", busy1); end
    commit(5'd7, 32'h77); #3;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL rr_rel1_same got=%b exp=1", busy1); end
    tick(); #3;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL rr_cnt1_busy got=%b exp=1", busy1); end
    checks++; if (rd1 !== 32'h77) begin errors++; $display("FAIL rr_rd got=%h exp=77", rd1); end
    commit(5'd7, 32'h78); #3;
    checks++; if (busy1 !== !c_byp) begin errors++; $display("FAIL rr_rel2_same got=%b exp=%b", busy1, !c_byp); end
    tick(); #3;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rr_cnt0_busy got=%b exp=0", busy1); end
    issue(5'd7); tick();
    issue(5'd7); commit(5'd7, 32'h79); #3;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL rr_both_same got=%b exp=1", busy1); end
    tick(); #3;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL rr_both_hold got=%b exp=1", busy1); end
    commit(5'd7, 32'h7A); tick(); #3;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rr_final_busy got=%b exp=0", busy1); end
  endtask

  task automatic test_overflow();
    ra2 = 5'd9;
    for (int k = 0; k < 3; k++) begin issue(5'd9); tick(); end
    #3;
    checks++; if (sb_overflow !== 1'b0) begin errors++; $display("FAIL ovf_at3 got=%b exp=0", sb_overflow); end
    issue(5'd9); tick(); #3;
    checks++; if (sb_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", sb_overflow); end
    checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL ovf_busy got=%b exp=1", busy2); end
    commit(5'd9, 32'h9); tick();
    commit(5'd9, 32'h9); tick(); #3;
    checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL ovf_held_at3 got=%b exp=1", busy2); end
    commit(5'd9, 32'h9); tick(); #3;
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL ovf_drained got=%b exp=0", busy2); end
    flush = 1; tick(); #3;
    checks++; if (sb_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flush got=%b exp=1", sb_overflow); end
    reset = 1; tick(); #3;
    checks++; if (sb_overflow !== 1'b0) begin errors++; $display("FAIL ovf_reset got=%b exp=0", sb_overflow); end
  endtask

  task automatic test_flush();
    ra1 = 5'd4;
    issue(5'd4); tick();
    issue(5'd4); tick(); #3;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL fl_pre_busy got=%b exp=1", busy1); end
    flush = 1; commit(5'd4, 32'h55); issue(5'd4);
    tick(); #3;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL fl_busy got=%b exp=0", busy1); end
    checks++; if (rd1 !== 32'h55) begin errors++; $display("FAIL fl_rd got=%h exp=55", rd1); end
  endtask

  task automatic test_reset_priority();
    commit(5'd3, 32'h1234); tick();
    ra1 = 5'd6; ra2 = 5'd3;
    issue(5'd6); tick();
    reset = 1; commit(5'd6, 32'hAA); issue(5'd6); flush = 1;
    tick(); #3;
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL rp_rd1 got=%h exp=0", rd1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rp_busy1 got=%b exp=0", busy1); end
    checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL rp_rd2 got=%h exp=0", rd2); end
  endtask

  initial begin
    reset = 1; ra1 = '0; ra2 = '0;
    issue_valid = 0; issue_wen = 0; issue_dst = '0;
    wvalid = 0; wa = '0; wd = '0; flush = 0;
    test_reset();
    test_write_read();
    test_x0();
    test_reserve_release();
    test_overflow();
    test_flush();
    test_reset_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile.md
# regfile

Architectural integer register file with an outstanding-write scoreboard, serving the decode stage's two register read ports and the writeback stage's single write port. Decode presents two source addresses and receives data plus a per-operand busy flag in the same cycle; it also reserves a destination register at issue. Writeback commits results and releases the reservations.

## Interface
Parameters:
- NREG, 32, number of architectural registers (index 0 hardwired to zero)
- CNT_W, 2, width of each per-register outstanding-write counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- ra1, ra2  in  creg_addr_t  source register addresses from decode
- rd1, rd2  out  word_t  source data, combinational from ra1/ra2
- busy1, busy2  out  1  source has an outstanding, uncommitted write
- issue_valid  in  1  decode issues an instruction this cycle
- issue_wen  in  1  the issued instruction writes a register
- issue_dst  in  creg_addr_t  destination of the issued instruction
- wvalid  in  1  writeback commits a result this cycle
- wa  in  creg_addr_t  writeback destination
- wd  in  word_t  writeback data
- flush  in  1  discard all reservations (pipeline flush)
- sb_overflow  out  1  sticky error: issue to a register whose counter is saturated

## Operation
- Reset: all registers 0, all counters 0, sb_overflow 0; rd1/rd2 read 0, busy1/busy2 0.
- Write: on clk, if wvalid and wa != 0, regs[wa] <= wd. Writes to x0 ignored.
- Read: rdN = regs[raN]; raN == 0 always yields 0 and busyN = 0.
- Reserve: issue_valid && issue_wen && issue_dst != 0 increments cnt[issue_dst].
- Release: wvalid && wa != 0 decrements cnt[wa]; decrement at 0 is ignored (no underflow).
- Same register reserved and released in one cycle: counter unchanged.
- Saturated counter (all ones) plus reserve without release: counter holds, sb_overflow set until reset.
- busyN = (cnt[raN] != 0), subject to bypass below.
- flush: all counters cleared next cycle; overrides any concurrent reserve; a concurrent wvalid still writes data. sb_overflow unaffected.
- Reset asserted mid-operation wins over flush, write and reserve in that cycle.

## Timing
- Read latency 0 (combinational ra->rd, ra->busy).
- Write/reserve/release/flush visible on the cycle after the clock edge that samples them.
- Without bypass, a result committed in cycle N is readable in cycle N+1.

## Configuration
- REGFILE_BYPASS_EN defined: write-through forwarding. If wvalid && wa == raN && wa != 0, rdN = wd in the same cycle, and busyN = (cnt[raN] > 1) or (cnt[raN] == 1 && reserve to raN this cycle) — i.e. the committing write is treated as already done.
- Undefined: no forwarding; rdN is the stored value, busyN = cnt[raN] != 0 regardless of concurrent writeback.

## Structure
- word_t, creg_addr_t in package common; add sb_cnt_t (logic [CNT_W-1:0]) to common.
- Sub-module regfile_scoreboard: counters, reserve/release/flush logic, sb_overflow, two combinational busy lookups (with bypass term under the macro). Top level holds data array, read muxes and bypass.

## Test plan
- Reset, then ra1=5, ra2=0 -> rd1=0, rd2=0, busy1=busy2=0.
- wvalid, wa=3, wd=0xDEAD_BEEF at cycle N, ra1=3 -> cycle N+1 rd1=0xDEADBEEF; cycle N rd1=0xDEADBEEF with REGFILE_BYPASS_EN, old value (0) without.
- Write wa=0, wd=1 -> ra1=0 reads 0; issue_dst=0 -> busy stays 0.
- Issue to x7 twice (cnt=2), one release -> busy1(ra1=7)=1; second release -> busy1=0 next cycle; same-cycle reserve+release on x7 keeps cnt.
- Reserve x9 three times, fourth reserve -> cnt stays 3, sb_overflow=1, persists through flush, cleared by reset.
- cnt[x4]=2, flush with concurrent wvalid wa=4 wd=0x55 -> next cycle busy=0, rd=0x55.
